fmul_result_buf: RTL
====================

FMUL_RESULT_BUF -- requirements
Module: fmul_result_buf

Interface
Parameters (name, default, meaning):
REQ-001 TAGW, 5, width of the destination tag carried with each multiply.
REQ-002 DEPTH, 4, result FIFO entries; SHALL be a power of two, 2 to 16.
Ports (name  direction  width  meaning):
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rstn  in  1  reset; synchronous and active-low.
REQ-005 issue_valid  in  1  upstream presents a multiply this cycle.
REQ-006 issue_ready  out  1  block can accept a multiply this cycle.
REQ-007 issue_x1, issue_x2  in  32  IEEE single operands.
REQ-008 issue_tag  in  TAGW  destination tag.
REQ-009 fmul_x1, fmul_x2  out  32  operands to the 2-cycle multiplier; combinational copy of issue_x1/issue_x2.
REQ-010 fmul_y  in  32  multiplier result; valid exactly 2 cycles after its operands were presented.
REQ-011 out_valid  out  1  FIFO head holds a result.
REQ-012 out_ready  in  1  downstream accepts the head this cycle.
REQ-013 out_data  out  32  head result.  REQ-014 out_tag  out  TAGW  head tag.

Function
REQ-015 Issue handshake: an issue occurs on a cycle with issue_valid=1 and issue_ready=1; issue_valid with issue_ready=0 SHALL have no effect.
REQ-016 In-flight tracking: 2-stage valid/tag shift register matches multiplier latency; an issue in cycle t SHALL push {fmul_y, tag} into the FIFO at the clock edge ending cycle t+2.
REQ-017 Latency: issue in cycle t with an empty FIFO SHALL give out_valid=1 in cycle t+3; back-to-back issues SHALL give back-to-back results in issue order.
REQ-018 Pop: occurs when out_valid=1 and out_ready=1; the next entry appears the following cycle; out_data/out_tag SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 Credit counter: credits = FIFO occupancy + in-flight count, width clog2(DEPTH)+1; +1 on issue, -1 on pop, unchanged when both occur in one cycle.
REQ-020 issue_ready SHALL be 1 iff credits < DEPTH (registered-counter compare, no dependence on out_ready); FIFO SHALL therefore never overflow.
REQ-021 Full case: at credits=DEPTH, a pop in cycle t SHALL raise issue_ready in cycle t+1.
REQ-022 Empty case: out_valid SHALL be 0 when occupancy is 0; out_ready while empty SHALL have no effect.
REQ-023 Read/write pointers clog2(DEPTH) bits, wrapping modulo DEPTH; push and pop in the same cycle SHALL both take effect, occupancy unchanged.
REQ-024 fmul_y SHALL be sampled only in cycles where the in-flight stage-2 valid is 1.

Reset
REQ-025 While rstn=0 at a clock edge: credits, occupancy, pointers and in-flight valids SHALL clear; out_valid=0 and issue_ready=1 from the following cycle.
REQ-026 FIFO data/tag storage SHALL NOT require reset; out_data/out_tag are don't-care while out_valid=0.
REQ-027 Reset mid-operation SHALL discard in-flight multiplies and FIFO contents; fmul_y results arriving after reset SHALL NOT be pushed.

Configuration
REQ-028 Macro FMUL_RBUF_FLAGS_EN: when defined, adds outputs out_zero (1 bit, head exponent field == 0) and out_neg (1 bit, head sign bit), each computed at push time and stored per entry; when undefined, these ports and storage SHALL be absent and all other behaviour identical.

Verification
REQ-029 Issue x1=0x40000000, x2=0x40400000, tag=3, FIFO empty, out_ready=1 -> out_valid=1 three cycles later with out_data=0x40C00000, out_tag=3.
REQ-030 Issue 0x00000000 * 0x3F800000 -> out_data=0x00000000; with FMUL_RBUF_FLAGS_EN, out_zero=1, out_neg=0; 0xBF800000*0x40000000 -> 0xC0000000, out_neg=1.
REQ-031 out_ready=0, issue tags 0..4 back-to-back -> issue_ready falls after 4th issue, tag 4 stalled; set out_ready=1 -> tags 0,1,2,3,4 pop in order, issue_ready rises the cycle after first pop.
REQ-032 credits=DEPTH with head valid, issue_valid=1, out_ready=1 in same cycle -> pop taken, issue not taken that cycle, issue accepted next cycle, credits return to DEPTH.
REQ-033 Continuous issue and out_ready=1 for 20 cycles -> one result per cycle, pointers wrap at least 4 times, no loss or reorder.
REQ-034 rstn=0 for one cycle with 2 in flight and 3 queued -> out_valid=0, issue_ready=1 next cycle; no stale result ever emerges.

Source files
------------

// File: rtl/fmul_result_buf.sv
// fmul_result_buf: in-order result FIFO behind a 2-cycle FP multiplier with credit-based issue control.
// Define FMUL_RBUF_FLAGS_EN to add per-entry out_zero/out_neg flags.
module fmul_result_buf #(
  parameter int TAGW  = 5,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [31:0]     issue_x1,
  input  logic [31:0]     issue_x2,
  input  logic [TAGW-1:0] issue_tag,
  output logic [31:0]     fmul_x1,
  output logic [31:0]     fmul_x2,
  input  logic [31:0]     fmul_y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  output logic [TAGW-1:0] out_tag
`ifdef FMUL_RBUF_FLAGS_EN
  ,
  output logic            out_zero,
  output logic            out_neg
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic            v1_q, v1_d, v2_q, v2_d;
  logic [TAGW-1:0] t1_q, t2_q;
  logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]   occ_q, occ_d, cred_q, cred_d;
  logic [31:0]     data_mem [DEPTH];
  logic [TAGW-1:0] tag_mem  [DEPTH];
  logic            issue, pop, push;
  assign fmul_x1     = issue_x1;
  assign fmul_x2     = issue_x2;
  assign issue_ready = cred_q < CW'(DEPTH);
  assign out_valid   = occ_q != '0;
  assign issue       = issue_valid & issue_ready;
  assign pop         = out_valid & out_ready;
  assign push        = v2_q;
  assign out_data    = data_mem[rp_q];
  assign out_tag     = tag_mem[rp_q];
  always_comb begin
    v1_d   = issue;
    v2_d   = v1_q;
    wp_d   = push ? wp_q + AW'(1) : wp_q;
    rp_d   = pop ? rp_q + AW'(1) : rp_q;
    occ_d  = occ_q + CW'(push) - CW'(pop);
    cred_d = cred_q + CW'(issue) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      wp_q   <= '0;
      rp_q   <= '0;
      occ_q  <= '0;
      cred_q <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      occ_q  <= occ_d;
      cred_q <= cred_d;
    end
  end
  // payload storage is unreset; the cleared valids and pointers make stale entries unreachable
  always_ff @(posedge clk) begin
    t1_q <= issue_tag;
    t2_q <= t1_q;
    if (push) begin
      data_mem[wp_q] <= fmul_y;
      tag_mem[wp_q]  <= t2_q;
    end
  end
`ifdef FMUL_RBUF_FLAGS_EN
  logic [1:0] flag_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (push) flag_mem[wp_q] <= {fmul_y[30:23] == 8'd0, fmul_y[31]};
  end
  assign out_zero = flag_mem[rp_q][1];
  assign out_neg  = flag_mem[rp_q][0];
`endif
endmodule
